// File: rtl/compound_rr_arbiter.sv
// compound_rr_arbiter
// Round-robin arbiter that shares one blocking output port between NUM_REQ
// blocking input ports. One word moves per grant: arbitrate, read the word
// from the winner, forward it, wait for the consumer, then arbitrate again.
//
// Handshake: every port uses sync/notify. A word moves on a port in exactly
// the cycle where that port's notify and sync are both high at the rising
// edge of clk. The arbiter drives notify (req_in_notify, arb_out_notify)
// from registers only; sync is owned by the partner on the other side.
module compound_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int GID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ*DATA_W-1:0] req_in,
  input  logic [NUM_REQ-1:0]        req_in_sync,
  output logic [NUM_REQ-1:0]        req_in_notify,
  output logic [DATA_W-1:0]         arb_out,
  input  logic                      arb_out_sync,
  output logic                      arb_out_notify,
  output logic [GID_W-1:0]          grant_id,
  output logic [1:0]                section
);

  typedef enum logic [1:0] {
    SECTION_ARB   = 2'd0,
    SECTION_READ  = 2'd1,
    SECTION_WRITE = 2'd2
  } section_t;

  section_t             state;
  logic [GID_W-1:0]     last_grant;
  logic                 pick_valid;
  logic [GID_W-1:0]     pick_idx;
  logic [GID_W-1:0]     cand;
  logic [DATA_W-1:0]    req_word [NUM_REQ];

  // Current section is visible for checkers and debug.
  assign section = state;

  // (base + offset) modulo NUM_REQ for offsets 1..NUM_REQ; works for
  // non-power-of-two NUM_REQ because the sum never exceeds 2*NUM_REQ-1.
  function automatic logic [GID_W-1:0] wrap_add(input logic [GID_W-1:0] base,
                                                input int offset);
    logic [GID_W:0] sum;
    sum = {1'b0, base} + (GID_W+1)'(offset);
    if (sum >= (GID_W+1)'(NUM_REQ)) sum = sum - (GID_W+1)'(NUM_REQ);
    return sum[GID_W-1:0];
  endfunction

  // Unpack the flat payload bus into one word per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_word[i] = req_in[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin search: scan from farthest to nearest candidate after
  // last_grant so the nearest requesting index is the one left standing.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = wrap_add(last_grant, i);
      if (req_in_sync[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Section FSM with all outputs registered; reset discards any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= SECTION_ARB;
      req_in_notify  <= '0;
      arb_out        <= '0;
      arb_out_notify <= 1'b0;
      grant_id       <= '0;
      last_grant     <= GID_W'(NUM_REQ - 1);
    end else begin
      case (state)
        SECTION_ARB: begin
          if (pick_valid) begin
            grant_id      <= pick_idx;
            req_in_notify <= NUM_REQ'(1) << pick_idx;
            state         <= SECTION_READ;
          end
        end
        SECTION_READ: begin
          // Wait on the granted requester only; no re-arbitration.
          if (req_in_sync[grant_id]) begin
            arb_out        <= req_word[grant_id];
            req_in_notify  <= '0;
            arb_out_notify <= 1'b1;
            state          <= SECTION_WRITE;
          end
        end
        SECTION_WRITE: begin
          // arb_out and grant_id are held until the consumer takes the word.
          if (arb_out_sync) begin
            arb_out_notify <= 1'b0;
            last_grant     <= grant_id;
            state          <= SECTION_ARB;
          end
        end
        default: begin
          state          <= SECTION_ARB;
          req_in_notify  <= '0;
          arb_out_notify <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/compound_rr_arbiter.md
# compound_rr_arbiter

Round-robin arbiter that shares one blocking output port between NUM_REQ blocking input ports, using the sync/notify handshake of our generated modules. Each granted requester delivers exactly one word. The block then forwards that word on the shared output and waits for the consumer to accept it before arbitrating again. It sits between several producer modules and a single consumer, for example in front of a TestBasic-style module's b_in port.

## Interface
- NUM_REQ, 4: number of requester input ports (2..16).
- DATA_W, 32: width of one transferred word (packed compound payload).
- GID_W, $clog2(NUM_REQ): width of grant index.

- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_in  in  NUM_REQ*DATA_W  request payloads; requester i occupies bits [i*DATA_W +: DATA_W].
- req_in_sync  in  NUM_REQ  requester i has a valid word.
- req_in_notify  out  NUM_REQ  arbiter is ready to read requester i (one-hot or zero).
- arb_out  out  DATA_W  forwarded word.
- arb_out_sync  in  1  consumer is ready to accept.
- arb_out_notify  out  1  arb_out holds a valid word.
- grant_id  out  GID_W  index of the requester whose word is in flight.

## Operation
- Transfer rule: a transfer on a port occurs in a cycle where its notify and sync are both high at the rising edge.
- All outputs are registered.
- State (Sections) is one of section_arb, section_read or section_write.
- section_arb:
  - All req_in_notify are 0 and arb_out_notify is 0.
  - If any req_in_sync bit is high, select the first requester with sync high, searching from last_grant+1 upward and wrapping at NUM_REQ.
  - Register the selection as grant_id, set req_in_notify[grant_id]=1, and go to section_read.
  - Otherwise stay in section_arb.
- section_read:
  - When req_in_sync[grant_id] is high, capture req_in slice grant_id into arb_out, clear req_in_notify, set arb_out_notify=1, and go to section_write.
  - If the requester drops sync, hold notify and wait indefinitely; there is no re-arbitration.
- section_write:
  - When arb_out_sync is high, clear arb_out_notify, set last_grant=grant_id, and return to section_arb.
  - arb_out and grant_id stay stable while arb_out_notify is high.
- Fairness: after requester k is served, k has lowest priority in the next arbitration. A continuously requesting set of N requesters is served in strict rotation.
- At most one word is in flight; there is no buffering beyond the arb_out register.

## Timing
- Reset values:
  - section = section_arb.
  - req_in_notify = 0.
  - arb_out = 0.
  - arb_out_notify = 0.
  - grant_id = 0.
  - last_grant = NUM_REQ-1, so requester 0 wins first.
- Latency with producer and consumer always ready:
  - Cycle 0: sync is seen in section_arb.
  - Cycle 1: req_in_notify is high and the input transfer occurs.
  - Cycle 2: arb_out_notify is high and the output transfer occurs.
  - Cycle 3: back in section_arb.
  - Throughput is therefore 1 word per 3 cycles.
- arb_out_sync is ignored outside section_write.
- req_in_sync of non-granted requesters is ignored outside section_arb.
- A sync arriving in the same cycle the block returns to section_arb is not seen until the next cycle's evaluation; there is no bypass.
- Reset asserted in any state immediately (asynchronously) forces all reset values. An in-flight word is discarded and no transfer is reported.
- Wrap-around: from last_grant=NUM_REQ-1 the search starts at 0.

## Test plan
- Reset mid-operation: in section_write with arb_out_notify=1, assert rst -> all outputs 0 asynchronously. After release, the next request from requester 0 wins first.
- Single requester: req_in_sync=4'b0100, word 0xA5A5_0002, arb_out_sync=1 ->
  - cycle 1: req_in_notify=4'b0100, grant_id=2;
  - cycle 2: arb_out=0xA5A5_0002, arb_out_notify=1;
  - cycle 3: arb_out_notify=0.
- Full contention: all four sync high continuously with consumer ready -> grant order 0,1,2,3,0. Each word appears exactly once with the matching grant_id.
- Consumer backpressure: arb_out_sync low for 5 cycles in section_write -> arb_out, grant_id and arb_out_notify are held stable. No req_in_notify is raised; the transfer completes on the cycle sync rises.
- Producer stall: the granted requester drops sync for 3 cycles in section_read -> req_in_notify stays high for that requester only. The word is captured only when sync returns.
- Priority rotation with wrap: last served=3, requesters 1 and 3 request -> 1 wins. Then requesters 1 and 3 request -> 3 wins.
